sweep_monitor: RTL and testbench
================================

Name: sweep_monitor

Overview:
- Receiving-end checker for the 4-bit up/down sweep counter stream.
- Samples a qualified count value each cycle and tracks full up-sweeps (0..MAX) and down-sweeps (MAX..0).
- Pulses on sweep completion, flags sequence violations and keeps saturating sweep and error statistics.
- Sits on the counter's output bus for integration checking and status reporting.

Parameters:
- CW, 4, count width of the observed stream (CW >= 2); MAX = 2^CW - 1
- SCW, 8, width of the sweep_cnt and err_cnt statistics counters

Ports:
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  reset, synchronous, active-low
- in_vld  input  1  cnt_in is valid this cycle
- cnt_in  input  CW  observed count value
- clr  input  1  synchronous clear of sweep_cnt and err_cnt
- tracking  output  1  1 while in UP_TRK or DN_TRK
- dir_up  output  1  1 in UP_TRK, 0 in DN_TRK; holds its last value in WAIT
- done_up  output  1  one-cycle pulse: up-sweep completed
- done_dn  output  1  one-cycle pulse: down-sweep completed
- seq_err  output  1  one-cycle pulse: sequence violation
- sweep_cnt  output  SCW  completed sweeps, saturating
- err_cnt  output  SCW  violations, saturating

Behaviour:
- All outputs are registered. Latency is 1 cycle from the sampled in_vld/cnt_in to the pulses, counters and state flags.
- Reset: on a clk edge with n_rst=0, state <= WAIT, exp <= 0, and every output <= 0. Reset mid-sweep discards progress; there is no error for the abandoned sweep.
- in_vld=0: state, exp and counters hold. Pulses are 0. cnt_in is ignored.
- Internal exp register (CW bits) holds the next expected value.
- WAIT (entry rule, also used for resync):
  - cnt_in==0 -> UP_TRK, exp=1
  - cnt_in==MAX -> DN_TRK, exp=MAX-1
  - any other value -> stay in WAIT, no error (joining mid-sweep)
- UP_TRK, on each valid sample:
  - cnt_in==exp and exp==MAX -> done_up, sweep_cnt+1, go to WAIT
  - cnt_in==exp and exp!=MAX -> exp+1
  - exp==1 and cnt_in==0 -> hold (start value repeated)
  - exp==1 and cnt_in==MAX -> DN_TRK, exp=MAX-1, no error (start retarget)
  - anything else -> seq_err, err_cnt+1, then apply the WAIT entry rule to the same cnt_in in the same cycle
- DN_TRK mirrors UP_TRK:
  - cnt_in==exp and exp==0 -> done_dn, sweep_cnt+1, go to WAIT
  - cnt_in==exp otherwise -> exp-1
  - exp==MAX-1 and cnt_in==MAX -> hold
  - exp==MAX-1 and cnt_in==0 -> UP_TRK, exp=1, no error
  - anything else -> seq_err, err_cnt+1, resync as above
- Completion sample: the 0 or MAX that completes a sweep is consumed and is NOT reused as a start. A fresh start needs the next valid sample.
- Counters: increment by 1 and saturate at all-ones; no wrap. clr has priority over a same-cycle increment (result 0). Pulses still fire when clr is active.
- State encoding: WAIT, UP_TRK, DN_TRK. Unused encodings -> WAIT.

Decomposition:
- Shared package: state enum (WAIT/UP_TRK/DN_TRK) and a MAX-value helper function of CW.
- One natural sub-module: sat_counter (params W; ports clk, n_rst, clr, inc, q), instantiated twice for sweep_cnt and err_cnt.

Test Plan:
- Up sweep: in_vld=1 with 0,0,1..F -> one cycle after the F sample: done_up=1 for one cycle, sweep_cnt=1, err_cnt=0, tracking=0.
- Down sweep after idle zeros: 0,0,F,F,E..0 -> no seq_err, dir_up=0 from the first F on, done_dn one cycle after the final 0, sweep_cnt=1.
- Violation: 0,1,2,5,0,1 -> seq_err one cycle after the 5, err_cnt=1, state WAIT; the following 0 enters UP_TRK with tracking=1.
- Valid gaps: 0,1, then in_vld=0 for 3 cycles with cnt_in=9, then 2..F -> done_up, err_cnt=0.
- Saturation/clear with SCW=2: 4 up-sweeps -> sweep_cnt=3. clr asserted in the same cycle as a final done -> sweep_cnt=0 and the done pulse is still seen.
- Reset mid-sweep: n_rst=0 for one edge at cnt_in=7 -> all outputs 0, state WAIT. Then 8,9 -> no error, tracking stays 0.

Source files
------------

// File: rtl/sweep_monitor_pkg.sv
// Shared types and helpers for the sweep stream monitor.
package sweep_monitor_pkg;

    typedef enum logic [1:0] {
        StWait  = 2'd0,
        StUpTrk = 2'd1,
        StDnTrk = 2'd2
    } state_e;

    // All-ones value of a cw-bit count, i.e. the sweep turnaround point.
    function automatic int unsigned max_val(input int unsigned cw);
        return (32'd1 << cw) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/sweep_monitor.sv
// Checks an up/down sweep count stream: tracks full sweeps, pulses on completion,
// flags sequence violations and keeps saturating statistics.
module sweep_monitor
    import sweep_monitor_pkg::*;
#(
    parameter int unsigned CW  = 4,
    parameter int unsigned SCW = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           in_vld,
    input  logic [CW-1:0]  cnt_in,
    input  logic           clr,
    output logic           tracking,
    output logic           dir_up,
    output logic           done_up,
    output logic           done_dn,
    output logic           seq_err,
    output logic [SCW-1:0] sweep_cnt,
    output logic [SCW-1:0] err_cnt
);

    localparam logic [CW-1:0] Max   = CW'(max_val(CW));
    localparam logic [CW-1:0] MaxM1 = Max - CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] exp_q, exp_d;
    logic          done_up_d, done_dn_d, seq_err_d;

    state_e        entry_state;
    logic [CW-1:0] entry_exp;

    // Entry rule, shared by WAIT and by resync after a violation.
    always_comb begin
        entry_state = StWait;
        entry_exp   = exp_q;
        if (cnt_in == '0) begin
            entry_state = StUpTrk;
            entry_exp   = CW'(1);
        end else if (cnt_in == Max) begin
            entry_state = StDnTrk;
            entry_exp   = MaxM1;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        done_up_d = 1'b0;
        done_dn_d = 1'b0;
        seq_err_d = 1'b0;
        case (state_q)
            StUpTrk: begin
                if (in_vld) begin
                    if (cnt_in == exp_q) begin
                        if (exp_q == Max) begin
                            done_up_d = 1'b1;
                            state_d   = StWait;
                        end else begin
                            exp_d = exp_q + CW'(1);
                        end
                    end else if (exp_q == CW'(1) && cnt_in == '0) begin
                        state_d = StUpTrk;
                    end else if (exp_q == CW'(1) && cnt_in == Max) begin
                        state_d = StDnTrk;
                        exp_d   = MaxM1;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = entry_state;
                        exp_d     = entry_exp;
                    end
                end
            end
            StDnTrk: begin
                if (in_vld) begin
                    if (cnt_in == exp_q) begin
                        if (exp_q == '0) begin
                            done_dn_d = 1'b1;
                            state_d   = StWait;
                        end else begin
                            exp_d = exp_q - CW'(1);
                        end
                    end else if (exp_q == MaxM1 && cnt_in == Max) begin
                        state_d = StDnTrk;
                    end else if (exp_q == MaxM1 && cnt_in == '0) begin
                        state_d = StUpTrk;
                        exp_d   = CW'(1);
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = entry_state;
                        exp_d     = entry_exp;
                    end
                end
            end
            StWait: begin
                if (in_vld) begin
                    state_d = entry_state;
                    exp_d   = entry_exp;
                end
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= StWait;
            exp_q    <= '0;
            tracking <= 1'b0;
            dir_up   <= 1'b0;
            done_up  <= 1'b0;
            done_dn  <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            tracking <= (state_d == StUpTrk) || (state_d == StDnTrk);
            if (state_d == StUpTrk) begin
                dir_up <= 1'b1;
            end else if (state_d == StDnTrk) begin
                dir_up <= 1'b0;
            end
            done_up  <= done_up_d;
            done_dn  <= done_dn_d;
            seq_err  <= seq_err_d;
        end
    end

    sat_counter #(
        .W(SCW)
    ) u_sweep_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clr),
        .inc   (done_up_d | done_dn_d),
        .q     (sweep_cnt)
    );

    sat_counter #(
        .W(SCW)
    ) u_err_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clr),
        .inc   (seq_err_d),
        .q     (err_cnt)
    );

endmodule

// File: tb/tb_sweep_monitor.sv
// Directed bench for sweep_monitor (CW=4, SCW=2 so saturation is reachable).
module tb_sweep_monitor;

    localparam int unsigned CW  = 4;
    localparam int unsigned SCW = 2;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           in_vld;
    logic [CW-1:0]  cnt_in;
    logic           clr;
    logic           tracking, dir_up, done_up, done_dn, seq_err;
    logic [SCW-1:0] sweep_cnt, err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sweep_monitor #(
        .CW  (CW),
        .SCW (SCW)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_vld    (in_vld),
        .cnt_in    (cnt_in),
        .clr       (clr),
        .tracking  (tracking),
        .dir_up    (dir_up),
        .done_up   (done_up),
        .done_dn   (done_dn),
        .seq_err   (seq_err),
        .sweep_cnt (sweep_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Drive one sample away from the edge, then look at the registered result.
    task automatic step(input logic vld, input logic [CW-1:0] c, input logic cl);
        @(negedge clk);
        in_vld = vld;
        cnt_in = c;
        clr    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [CW-1:0] c);
        @(negedge clk);
        n_rst  = 1'b0;
        in_vld = 1'b1;
        cnt_in = c;
        clr    = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tracking"}, 32'(tracking), 0);
        check_eq({tag, "_dir_up"},   32'(dir_up),   0);
        check_eq({tag, "_done_up"},  32'(done_up),  0);
        check_eq({tag, "_done_dn"},  32'(done_dn),  0);
        check_eq({tag, "_seq_err"},  32'(seq_err),  0);
        check_eq({tag, "_sweep"},    32'(sweep_cnt), 0);
        check_eq({tag, "_err"},      32'(err_cnt),  0);
    endtask

    task automatic up_sweep();
        for (int v = 0; v <= 15; v++) step(1'b1, CW'(v), 1'b0);
    endtask

    int err_seen;

    initial begin
        n_rst = 1'b0; in_vld = 1'b0; cnt_in = '0; clr = 1'b0;

        do_reset(4'd0);
        check_all_zero("reset");

        // Up sweep 0,0,1..F
        step(1'b1, 4'd0, 1'b0);
        check_eq("up_start_trk", 32'(tracking), 1);
        check_eq("up_start_dir", 32'(dir_up), 1);
        step(1'b1, 4'd0, 1'b0);
        check_eq("up_hold_err", 32'(seq_err), 0);
        for (int v = 1; v <= 14; v++) step(1'b1, CW'(v), 1'b0);
        check_eq("up_pre_done", 32'(done_up), 0);
        step(1'b1, 4'hF, 1'b0);
        check_eq("up_done", 32'(done_up), 1);
        check_eq("up_sweep", 32'(sweep_cnt), 1);
        check_eq("up_err", 32'(err_cnt), 0);
        check_eq("up_trk_off", 32'(tracking), 0);
        check_eq("up_dir_hold", 32'(dir_up), 1);
        step(1'b0, 4'd0, 1'b0);
        check_eq("up_done_pulse", 32'(done_up), 0);
        check_eq("up_sweep_hold", 32'(sweep_cnt), 1);

        // Down sweep after idle zeros: 0,0,F,F,E..0
        do_reset(4'd0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        check_eq("dn_retarget_dir", 32'(dir_up), 0);
        check_eq("dn_retarget_trk", 32'(tracking), 1);
        check_eq("dn_retarget_err", 32'(seq_err), 0);
        err_seen = 0;
        step(1'b1, 4'hF, 1'b0);
        err_seen += int'(seq_err);
        for (int v = 14; v >= 1; v--) begin
            step(1'b1, CW'(v), 1'b0);
            err_seen += int'(seq_err);
        end
        check_eq("dn_no_err", 32'(err_seen), 0);
        check_eq("dn_pre_done", 32'(done_dn), 0);
        step(1'b1, 4'd0, 1'b0);
        check_eq("dn_done", 32'(done_dn), 1);
        check_eq("dn_sweep", 32'(sweep_cnt), 1);
        check_eq("dn_dir_hold", 32'(dir_up), 0);
        check_eq("dn_trk_off", 32'(tracking), 0);
        // Completion 0 was consumed; a fresh 0 starts a new up-sweep.
        step(1'b1, 4'd0, 1'b0);
        check_eq("dn_fresh_start", 32'(dir_up), 1);
        check_eq("dn_done_pulse", 32'(done_dn), 0);

        // Violation: 0,1,2,5,0,1
        do_reset(4'd0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        check_eq("viol_pre", 32'(seq_err), 0);
        step(1'b1, 4'd5, 1'b0);
        check_eq("viol_err", 32'(seq_err), 1);
        check_eq("viol_cnt", 32'(err_cnt), 1);
        check_eq("viol_wait", 32'(tracking), 0);
        step(1'b1, 4'd0, 1'b0);
        check_eq("viol_pulse", 32'(seq_err), 0);
        check_eq("viol_restart", 32'(tracking), 1);
        step(1'b1, 4'd1, 1'b0);
        check_eq("viol_cont", 32'(tracking), 1);
        check_eq("viol_cnt_hold", 32'(err_cnt), 1);

        // Valid gaps: 0,1, gap x3 with 9, then 2..F
        do_reset(4'd0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd9, 1'b0);
        check_eq("gap_trk", 32'(tracking), 1);
        check_eq("gap_err", 32'(seq_err), 0);
        for (int v = 2; v <= 15; v++) step(1'b1, CW'(v), 1'b0);
        check_eq("gap_done", 32'(done_up), 1);
        check_eq("gap_err_cnt", 32'(err_cnt), 0);
        check_eq("gap_sweep", 32'(sweep_cnt), 1);

        // Saturation at 3, then clear beats a same-cycle completion
        do_reset(4'd0);
        for (int s = 0; s < 3; s++) up_sweep();
        check_eq("sat_3", 32'(sweep_cnt), 3);
        up_sweep();
        check_eq("sat_hold", 32'(sweep_cnt), 3);
        for (int v = 0; v <= 14; v++) step(1'b1, CW'(v), 1'b0);
        step(1'b1, 4'hF, 1'b1);
        check_eq("clr_done", 32'(done_up), 1);
        check_eq("clr_sweep", 32'(sweep_cnt), 0);

        // Error counter saturation: UP_TRK exp=1 then 7 -> error each time
        do_reset(4'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'd0, 1'b0);
            step(1'b1, 4'd7, 1'b0);
        end
        check_eq("err_sat", 32'(err_cnt), 3);

        // Reset mid-sweep at 7, then 8,9
        do_reset(4'd0);
        for (int v = 0; v <= 6; v++) step(1'b1, CW'(v), 1'b0);
        check_eq("mid_trk", 32'(tracking), 1);
        do_reset(4'd7);
        check_all_zero("mid_rst");
        step(1'b1, 4'd8, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        check_eq("mid_no_err", 32'(seq_err), 0);
        check_eq("mid_err_cnt", 32'(err_cnt), 0);
        check_eq("mid_trk_off", 32'(tracking), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
